// File: rtl/mux_16b4.sv
// mux_16b4: registered 4-to-1 word multiplexer for the datapath.
// Selects one of A/B/C/D by the low two bits of S. Any set bit above
// bit 1 of S is an illegal code and raises sel_err.
// Optional build macro: MUX16B4_SEL_HOLD_EN -- on an illegal code, O keeps
// its previous value instead of being cleared.
module mux_16b4 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [SEL_W-1:0] S,
    output logic [WIDTH-1:0] O,
    output logic             sel_err
);

    logic             sel_bad;
    logic [WIDTH-1:0] o_nxt;

    // Upper select bits only exist when SEL_W > 2; a pure 2-bit select
    // can never be illegal.
    generate
        if (SEL_W > 2) begin : g_sel_hi
            assign sel_bad = |S[SEL_W-1:2];
        end else begin : g_sel_ok
            assign sel_bad = 1'b0;
        end
    endgenerate

    // Next-word selection; illegal codes clear or hold depending on build.
    always_comb begin
        o_nxt = '0;
        if (sel_bad) begin
`ifdef MUX16B4_SEL_HOLD_EN
            o_nxt = O;
`else
            o_nxt = '0;
`endif
        end else begin
            case (S[1:0])
                2'd0:    o_nxt = A;
                2'd1:    o_nxt = B;
                2'd2:    o_nxt = C;
                default: o_nxt = D;
            endcase
        end
    end

    // Output register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O       <= '0;
            sel_err <= 1'b0;
        end else begin
            O       <= o_nxt;
            sel_err <= sel_bad;
        end
    end

endmodule

// File: tb/tb_mux_16b4.sv
// tb_mux_16b4: directed self-checking bench for mux_16b4.
// Build with MUX16B4_SEL_HOLD_EN defined to check the hold-on-illegal build.
module tb_mux_16b4;

    logic        clk;
    logic        rst_n;
    logic [15:0] A, B, C, D;
    logic [2:0]  S;
    logic [15:0] O;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    mux_16b4 #(.WIDTH(16), .SEL_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .S       (S),
        .O       (O),
        .sel_err (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%04h expected 'h%04h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_ill;

    initial begin
        rst_n = 1'b0;
        A = 16'hA534; B = 16'hDAFD; C = 16'hDFDF; D = 16'hAAAA;
        S = 3'd0;

        // Reset held while clocking
        #2;
        chk("rst_o_pre_edge", O, 16'h0);
        step(); step();
        chk("rst_o", O, 16'h0);
        chk("rst_err", {15'h0, sel_err}, 16'h0);

        // Release; first edge captures A
        rst_n = 1'b1;
        step();
        chk("rel_o_A", O, 16'hA534);
        chk("rel_err", {15'h0, sel_err}, 16'h0);

        // Select B, and confirm no combinational path before the edge
        S = 3'd1;
        #2;
        chk("comb_B_hold", O, 16'hA534);
        step();
        chk("sel_B", O, 16'hDAFD);
        chk("sel_B_err", {15'h0, sel_err}, 16'h0);

        S = 3'd2;
        step();
        chk("sel_C", O, 16'hDFDF);

        S = 3'd3;
        #2;
        chk("comb_D_hold", O, 16'hDFDF);
        step();
        chk("sel_D", O, 16'hAAAA);
        chk("sel_D_err", {15'h0, sel_err}, 16'h0);

        // Illegal code
`ifdef MUX16B4_SEL_HOLD_EN
        exp_ill = 16'hAAAA;
`else
        exp_ill = 16'h0000;
`endif
        S = 3'd5;
        step();
        chk("ill5_o", O, exp_ill);
        chk("ill5_err", {15'h0, sel_err}, 16'h1);

        S = 3'd1;
        step();
        chk("recov_B", O, 16'hDAFD);
        chk("recov_err", {15'h0, sel_err}, 16'h0);

        // Async reset mid-stream
        S = 3'd2;
        step();
        chk("pre_rst_C", O, 16'hDFDF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_o", O, 16'h0);
        chk("async_rst_err", {15'h0, sel_err}, 16'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_C", O, 16'hDFDF);

        // Back-to-back select sweep
        S = 3'd0; step(); chk("b2b_0", O, 16'hA534);
        S = 3'd1; step(); chk("b2b_1", O, 16'hDAFD);
        S = 3'd2; step(); chk("b2b_2", O, 16'hDFDF);
        S = 3'd3; step(); chk("b2b_3", O, 16'hAAAA);
        S = 3'd0; step(); chk("b2b_4", O, 16'hA534);
        chk("b2b_err", {15'h0, sel_err}, 16'h0);

        // Illegal codes 7 and 4 from a different held word
`ifdef MUX16B4_SEL_HOLD_EN
        exp_ill = 16'hA534;
`else
        exp_ill = 16'h0000;
`endif
        S = 3'd7; step();
        chk("ill7_o", O, exp_ill);
        chk("ill7_err", {15'h0, sel_err}, 16'h1);
        S = 3'd4; step();
        chk("ill4_o", O, exp_ill);
        chk("ill4_err", {15'h0, sel_err}, 16'h1);

        // Simultaneous select and data change: new data of new input wins
        S = 3'd3; D = 16'h1234; C = 16'h5678;
        step();
        chk("simul_D", O, 16'h1234);
        chk("simul_err", {15'h0, sel_err}, 16'h0);
        S = 3'd2; C = 16'h0F0F;
        step();
        chk("simul_C", O, 16'h0F0F);

        // All-ones and all-zeros pass bit-exact
        A = 16'hFFFF; B = 16'h0000;
        S = 3'd0; step(); chk("ones_A", O, 16'hFFFF);
        S = 3'd1; step(); chk("zero_B", O, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_16b4.md
Name: mux_16b4

Overview:
- Registered 4-to-1 word multiplexer used in the processor datapath to pick one of four 16-bit sources (register file, immediate, ALU, memory paths).
- Select is 3 bits wide to match the control-unit field. Only codes 0..3 are legal.
- Output is registered on the single system clock and cleared by the asynchronous active-low reset.
- Also flags illegal select codes.

Parameters:
- WIDTH, 16, data width of A, B, C, D and O.
- SEL_W, 3, width of select S. Must be at least 2; only the low 2 bits index inputs.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  source 0.
- B  input  WIDTH  source 1.
- C  input  WIDTH  source 2.
- D  input  WIDTH  source 3.
- S  input  SEL_W  select code.
- O  output  WIDTH  registered selected word.
- sel_err  output  1  registered flag: S was outside 0..3 at the last capture.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Reset: while rst_n=0, O=0 and sel_err=0 immediately, regardless of clk. Deassertion is sampled at the next rising clk edge.
- Selection, at each rising clk with rst_n=1:
  - S=0 → O<=A
  - S=1 → O<=B
  - S=2 → O<=C
  - S=3 → O<=D
  - sel_err<=0 for all four codes.
- Illegal select S=4..7 (any nonzero bit above bit 1): O<=0, sel_err<=1. The behaviour changes under the optional feature below.
- Latency: exactly one clk edge from stable A/B/C/D/S to O. No combinational path from any input to O.
- Data is passed bit-exact: no arithmetic, no sign extension, no width conversion.
- Input changes between edges have no effect until the next edge. No glitches on O between edges.
- Reset asserted mid-operation clears O and sel_err asynchronously. The first edge after release captures per the current S.
- Simultaneous change of S and data before an edge: the captured word is the new data of the newly selected input.
- X or Z on S: the implementation has no obligation; the bench must not drive it.

Optional Feature:
- Macro: MUX16B4_SEL_HOLD_EN.
- Defined: an illegal S (4..7) leaves O holding its previous value instead of clearing it; sel_err<=1 as normal.
- Not defined: an illegal S forces O<=0 and sel_err<=1.
- Legal-code and reset behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with A='hA534, S=0 while clocking → O=0, sel_err=0. Release rst_n → after one edge, O='hA534.
- Select A and B: A='hA534, B='hDAFD, C='hDFDF, D='hAAAA. S=0 → after one edge O='hA534. S=1 → O='hDAFD. sel_err=0 throughout.
- Select C and D: same data. S=2 → O='hDFDF. S=3 → O='hAAAA. Also check O is unchanged before the edge (no combinational path).
- Illegal select: after O='hAAAA, set S=5.
  - Default build → O=0, sel_err=1.
  - With MUX16B4_SEL_HOLD_EN → O='hAAAA, sel_err=1.
  - Then S=1 → O='hDAFD, sel_err=0.
- Async reset mid-stream: with O='hDFDF, pulse rst_n low between edges → O=0 immediately, with no clk edge needed.
- Back-to-back: change S every cycle through 0,1,2,3,0 → O follows one cycle later: 'hA534, 'hDAFD, 'hDFDF, 'hAAAA, 'hA534.
